// File: rtl/ex_mem_skid_pkg.sv
// ex_mem_skid_pkg: shared widths, reset level and stage FSM encoding
package ex_mem_skid_pkg;
    localparam int   REG_LEN      = 32;
    localparam int   REG_ADDR_LEN = 5;
    localparam logic RESET_ENABLE = 1'b1;
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;
endpackage

// File: rtl/ex_mem_skid_if.sv
// ex_mem_skid_if: EX-side and MEM-side valid/ready handshake bundle
interface ex_mem_skid_if
    import ex_mem_skid_pkg::*;
#(
    parameter int DATA_W = REG_LEN,
    parameter int ADDR_W = REG_ADDR_LEN
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_rd_data;
    logic [ADDR_W-1:0] in_rd_addr;
    logic              in_rd_enable;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_rd_data;
    logic [ADDR_W-1:0] out_rd_addr;
    logic              out_rd_enable;
    modport master (
        output in_valid, in_rd_data, in_rd_addr, in_rd_enable, out_ready,
        input  in_ready, out_valid, out_rd_data, out_rd_addr, out_rd_enable
    );
    modport slave (
        input  in_valid, in_rd_data, in_rd_addr, in_rd_enable, out_ready,
        output in_ready, out_valid, out_rd_data, out_rd_addr, out_rd_enable
    );
endinterface

// File: rtl/ex_mem_skid.sv
// ex_mem_skid: EX->MEM stage register with two-entry skid buffer, flush and forwarding tap
module ex_mem_skid
    import ex_mem_skid_pkg::*;
#(
    parameter int DATA_W = REG_LEN,
    parameter int ADDR_W = REG_ADDR_LEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    ex_mem_skid_if.slave     bus,
    output logic             fwd_enable,
    output logic [1:0]       occupancy
);
    state_t            r_state;
    state_t            w_next;
    logic              r_in_ready;
    logic [DATA_W-1:0] r_main_data;
    logic [ADDR_W-1:0] r_main_addr;
    logic              r_main_en;
    logic [DATA_W-1:0] r_skid_data;
    logic [ADDR_W-1:0] r_skid_addr;
    logic              r_skid_en;
    logic              w_in_xfer;
    logic              w_out_xfer;
    logic              w_load_main;
    logic              w_main_from_skid;
    logic              w_load_skid;

    assign w_in_xfer  = bus.in_valid & r_in_ready;
    assign w_out_xfer = (r_state != EMPTY) & bus.out_ready;

    // flush overrides every transition and load; an out transfer in the same cycle is simply dropped from state
    always_comb begin
        w_next           = r_state;
        w_load_main      = 1'b0;
        w_main_from_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            EMPTY: begin
                w_next      = w_in_xfer ? ONE : EMPTY;
                w_load_main = w_in_xfer;
            end
            ONE: begin
                w_next      = (w_in_xfer & !w_out_xfer) ? TWO :
                              (w_out_xfer & !w_in_xfer) ? EMPTY : ONE;
                w_load_main = w_in_xfer & w_out_xfer;
                w_load_skid = w_in_xfer & !w_out_xfer;
            end
            TWO: begin
                w_next           = w_out_xfer ? ONE : TWO;
                w_main_from_skid = w_out_xfer;
            end
            default: w_next = EMPTY;
        endcase
        if (flush) begin
            w_next           = EMPTY;
            w_load_main      = 1'b0;
            w_main_from_skid = 1'b0;
            w_load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RESET_ENABLE) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_main_data <= '0;
            r_main_addr <= '0;
            r_main_en   <= 1'b0;
            r_skid_data <= '0;
            r_skid_addr <= '0;
            r_skid_en   <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_in_ready <= (w_next != TWO);
            if (w_load_main) begin
                r_main_data <= bus.in_rd_data;
                r_main_addr <= bus.in_rd_addr;
                r_main_en   <= bus.in_rd_enable;
            end else if (w_main_from_skid) begin
                r_main_data <= r_skid_data;
                r_main_addr <= r_skid_addr;
                r_main_en   <= r_skid_en;
            end
            if (w_load_skid) begin
                r_skid_data <= bus.in_rd_data;
                r_skid_addr <= bus.in_rd_addr;
                r_skid_en   <= bus.in_rd_enable;
            end
        end
    end

    assign bus.in_ready      = r_in_ready;
    assign bus.out_valid     = (r_state != EMPTY);
    assign bus.out_rd_data   = r_main_data;
    assign bus.out_rd_addr   = r_main_addr;
    assign bus.out_rd_enable = r_main_en;
    assign fwd_enable        = bus.out_valid & r_main_en & (r_main_addr != '0);
    assign occupancy         = r_state;
endmodule

// File: tb/tb_ex_mem_skid.sv
// tb_ex_mem_skid: queue-model check of ex_mem_skid with directed and random traffic
module tb_ex_mem_skid;
    typedef struct packed {
        logic [31:0] d;
        logic [4:0]  a;
        logic        e;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       fwd_enable;
    logic [1:0] occupancy;
    int         checks = 0;
    int         failures = 0;
    bit         run = 1'b0;
    bit         m_rdy = 1'b1;
    beat_t      q[$];

    ex_mem_skid_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    ex_mem_skid #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .bus(bus.slave),
        .fwd_enable(fwd_enable),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    // drive one cycle of inputs, advance the queue model across the edge, return at the next negedge
    task automatic step(input bit v, input logic [31:0] d, input logic [4:0] a, input bit e,
                        input bit ordy, input bit fl);
        bit ix;
        bit ox;
        beat_t b;
        bus.in_valid     = v;
        bus.in_rd_data   = d;
        bus.in_rd_addr   = a;
        bus.in_rd_enable = e;
        bus.out_ready    = ordy;
        flush            = fl;
        @(posedge clk);
        ix = v && m_rdy;
        ox = (q.size() > 0) && ordy;
        b  = '{d: d, a: a, e: e};
        if (fl) q.delete();
        else begin
            if (ox) void'(q.pop_front());
            if (ix) q.push_back(b);
        end
        m_rdy = (q.size() < 2);
        @(negedge clk);
    endtask

    task automatic idle(input bit ordy);
        step(1'b0, 32'h0, 5'h0, 1'b0, ordy, 1'b0);
    endtask

    always @(negedge clk) begin
        if (run && !rst) begin
            chk("in_ready", bus.in_ready, m_rdy);
            chk("out_valid", bus.out_valid, q.size() > 0);
            chk("occupancy", occupancy, q.size());
            chk("fwd_enable", fwd_enable, (q.size() > 0) && q[0].e && (q[0].a != 0));
            if (q.size() > 0) begin
                chk("out_rd_data", bus.out_rd_data, q[0].d);
                chk("out_rd_addr", bus.out_rd_addr, q[0].a);
                chk("out_rd_enable", bus.out_rd_enable, q[0].e);
            end
        end
    end

    initial begin
        bus.in_valid = 0; bus.in_rd_data = 0; bus.in_rd_addr = 0; bus.in_rd_enable = 0; bus.out_ready = 0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_data", bus.out_rd_data, 0);
        rst = 1'b0;
        run = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 32'h11 * i, 5'(i), 1'b1, 1'b1, 1'b0);
            chk("stream_data", bus.out_rd_data, 32'h11 * i);
            chk("stream_in_ready", bus.in_ready, 1);
        end
        idle(1'b1);
        chk("stream_drained", bus.out_valid, 0);
        step(1'b1, 32'hAAAA_0001, 5'd3, 1'b1, 1'b0, 1'b0);
        chk("bp_occ1", occupancy, 1);
        step(1'b1, 32'hBBBB_0002, 5'd4, 1'b1, 1'b0, 1'b0);
        chk("bp_occ2", occupancy, 2);
        chk("bp_in_ready", bus.in_ready, 0);
        chk("bp_hold_a", bus.out_rd_data, 32'hAAAA_0001);
        idle(1'b0);
        chk("bp_still_a", bus.out_rd_data, 32'hAAAA_0001);
        idle(1'b1);
        chk("bp_then_b", bus.out_rd_data, 32'hBBBB_0002);
        chk("bp_b_addr", bus.out_rd_addr, 4);
        idle(1'b1);
        chk("bp_empty", bus.out_valid, 0);
        step(1'b1, 32'hAAAA_0001, 5'd3, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'hBBBB_0002, 5'd4, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'hDEAD_BEEF, 5'd9, 1'b1, 1'b0, 1'b1);
        chk("flush_valid", bus.out_valid, 0);
        chk("flush_occ", occupancy, 0);
        chk("flush_in_ready", bus.in_ready, 1);
        idle(1'b1);
        chk("flush_no_ghost", bus.out_valid, 0);
        step(1'b1, 32'h0000_0C0C, 5'd5, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0D0D, 5'd6, 1'b1, 1'b1, 1'b1);
        chk("flush_one_drop", bus.out_valid, 0);
        step(1'b1, 32'h1, 5'd0, 1'b1, 1'b1, 1'b0);
        chk("fwd_x0", fwd_enable, 0);
        step(1'b1, 32'h2, 5'd7, 1'b1, 1'b1, 1'b0);
        chk("fwd_r7", fwd_enable, 1);
        step(1'b1, 32'h3, 5'd7, 1'b0, 1'b1, 1'b0);
        chk("fwd_r7_noen", fwd_enable, 0);
        idle(1'b1);
        step(1'b1, 32'h5555_0001, 5'd1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h5555_0002, 5'd2, 1'b1, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_in_ready", bus.in_ready, 1);
        chk("arst_occ", occupancy, 0);
        chk("arst_fwd", fwd_enable, 0);
        chk("arst_data", bus.out_rd_data, 0);
        chk("arst_addr", bus.out_rd_addr, 0);
        chk("arst_en", bus.out_rd_enable, 0);
        q.delete();
        m_rdy = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(1'b1);
        idle(1'b0);
        chk("post_rst_idle", bus.out_valid, 0);
        step(1'b1, 32'h7777_0007, 5'd7, 1'b1, 1'b0, 1'b0);
        chk("post_rst_beat", bus.out_rd_data, 32'h7777_0007);
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 1) == 1, $urandom, 5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 24) == 0);
        end
        run = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
